// File: rtl/fetch_ctrl_pkg.sv
// rtl/fetch_ctrl_pkg.sv - shared types and constants for the fetch controller
package fetch_ctrl_pkg;

   typedef enum logic [1:0] {
      BOOT      = 2'd0,
      RUN       = 2'd1,
      IMEM_WAIT = 2'd2
   } fetch_state_t;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
   localparam logic [31:0] PC_INC           = 32'd4;

   // Redirect targets are always word aligned before they reach the PC
   function automatic logic [31:0] align_target(input logic [31:0] target);
      return target & ~32'd3;
   endfunction

   function automatic logic is_misaligned(input logic [1:0] low_bits);
      return low_bits != 2'b00;
   endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up counter with synchronous clear
module sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             clear,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   // Count up on inc, stick at all-ones, clear has priority
   always_ff @(posedge clk) begin
      if (clear) begin
         count <= '0;
      end else if (inc && (count != {CNT_W{1'b1}})) begin
         count <= count + CNT_W'(1);
      end
   end

endmodule

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - PC sequencing, redirect and stall control for the fetch stage
module fetch_ctrl
   import fetch_ctrl_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
   parameter int          CNT_W    = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [31:0]      pc,
   input  logic             imem_ready,
   input  logic             load_use,
   input  logic             jump,
   input  logic [31:0]      jump_target,
   input  logic             br_taken,
   input  logic [31:0]      br_target,
   output logic             PCWr,
   output logic [31:0]      NPC,
   output logic             ifid_wr,
   output logic             ifid_flush,
   output logic             idex_flush,
   output logic             misalign,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] redir_cnt
);

   fetch_state_t state, state_nxt;
   logic         redir_vld, redir_vld_nxt;
   logic [31:0]  redir_buf, redir_buf_nxt;
   logic         stall_inc;
   logic         redir_inc;

   // State and redirect buffer registers; reset drops any pending redirect
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= BOOT;
         redir_vld <= 1'b0;
         redir_buf <= '0;
      end else begin
         state     <= state_nxt;
         redir_vld <= redir_vld_nxt;
         redir_buf <= redir_buf_nxt;
      end
   end

   // Next-state and control outputs, all combinational so they act in the same cycle
   always_comb begin
      state_nxt     = state;
      redir_vld_nxt = redir_vld;
      redir_buf_nxt = redir_buf;
      PCWr          = 1'b0;
      NPC           = pc + PC_INC;
      ifid_wr       = 1'b0;
      ifid_flush    = 1'b0;
      idex_flush    = 1'b0;
      misalign      = 1'b0;
      redir_inc     = 1'b0;

      if (rst) begin
         NPC        = RESET_PC;
         ifid_flush = 1'b1;
         idex_flush = 1'b1;
         state_nxt  = BOOT;
      end else begin
         unique case (state)
            BOOT: begin
               PCWr       = 1'b1;
               NPC        = RESET_PC;
               ifid_flush = 1'b1;
               idex_flush = 1'b1;
               state_nxt  = RUN;
            end
            RUN: begin
               if (br_taken) begin
                  PCWr       = 1'b1;
                  NPC        = align_target(br_target);
                  misalign   = is_misaligned(br_target[1:0]);
                  ifid_flush = 1'b1;
                  idex_flush = 1'b1;
                  redir_inc  = 1'b1;
               end else if (jump) begin
                  PCWr       = 1'b1;
                  NPC        = align_target(jump_target);
                  misalign   = is_misaligned(jump_target[1:0]);
                  ifid_flush = 1'b1;
                  redir_inc  = 1'b1;
               end else if (load_use) begin
                  idex_flush = 1'b1;
               end else if (!imem_ready) begin
                  ifid_flush = 1'b1;
                  state_nxt  = IMEM_WAIT;
               end else begin
                  PCWr    = 1'b1;
                  ifid_wr = 1'b1;
               end
            end
            IMEM_WAIT: begin
               // ID holds a bubble here, so only EX branches matter
               if (br_taken) begin
                  idex_flush = 1'b1;
                  misalign   = is_misaligned(br_target[1:0]);
               end
               if (imem_ready) begin
                  state_nxt = RUN;
                  PCWr      = 1'b1;
                  if (br_taken || redir_vld) begin
                     NPC           = br_taken ? align_target(br_target) : redir_buf;
                     ifid_flush    = 1'b1;
                     redir_inc     = 1'b1;
                     redir_vld_nxt = 1'b0;
                  end else begin
                     ifid_wr = 1'b1;
                  end
               end else begin
                  ifid_flush = 1'b1;
                  if (br_taken) begin
                     redir_vld_nxt = 1'b1;
                     redir_buf_nxt = align_target(br_target);
                  end
               end
            end
            default: begin
               state_nxt = BOOT;
            end
         endcase
      end
   end

   assign stall_inc = !rst && ((state == RUN) || (state == IMEM_WAIT)) && !PCWr;

   sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .clear (rst),
      .inc   (stall_inc),
      .count (stall_cnt)
   );

   sat_counter #(.CNT_W(CNT_W)) u_redir_cnt (
      .clk   (clk),
      .clear (rst),
      .inc   (redir_inc),
      .count (redir_cnt)
   );

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - directed vector bench for fetch_ctrl
module tb_fetch_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] pc;
   logic        imem_ready;
   logic        load_use;
   logic        jump;
   logic [31:0] jump_target;
   logic        br_taken;
   logic [31:0] br_target;
   logic        PCWr;
   logic [31:0] NPC;
   logic        ifid_wr;
   logic        ifid_flush;
   logic        idex_flush;
   logic        misalign;
   logic [15:0] stall_cnt;
   logic [15:0] redir_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   fetch_ctrl dut (
      .clk         (clk),
      .rst         (rst),
      .pc          (pc),
      .imem_ready  (imem_ready),
      .load_use    (load_use),
      .jump        (jump),
      .jump_target (jump_target),
      .br_taken    (br_taken),
      .br_target   (br_target),
      .PCWr        (PCWr),
      .NPC         (NPC),
      .ifid_wr     (ifid_wr),
      .ifid_flush  (ifid_flush),
      .idex_flush  (idex_flush),
      .misalign    (misalign),
      .stall_cnt   (stall_cnt),
      .redir_cnt   (redir_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic [31:0] pc;
      logic        rdy;
      logic        lu;
      logic        jmp;
      logic [31:0] jt;
      logic        br;
      logic [31:0] bt;
      logic        pcwr;
      logic [31:0] npc;
      logic        chk_npc;
      logic        wr;
      logic        fl;
      logic        ix;
      logic        mis;
   } vec_t;

   function automatic vec_t mk(
      input logic r, input logic [31:0] p, input logic rdy, input logic lu,
      input logic jmp, input logic [31:0] jt, input logic br, input logic [31:0] bt,
      input logic pcwr, input logic [31:0] npc, input logic chk_npc,
      input logic wr, input logic fl, input logic ix, input logic mis);
      vec_t v;
      v.rst = r;   v.pc = p;    v.rdy = rdy; v.lu = lu;
      v.jmp = jmp; v.jt = jt;   v.br = br;   v.bt = bt;
      v.pcwr = pcwr; v.npc = npc; v.chk_npc = chk_npc;
      v.wr = wr;   v.fl = fl;   v.ix = ix;   v.mis = mis;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Drive one cycle of inputs, compare the combinational outputs, then clock
   task automatic step(input vec_t v, input string nm);
      rst = v.rst; pc = v.pc; imem_ready = v.rdy; load_use = v.lu;
      jump = v.jmp; jump_target = v.jt; br_taken = v.br; br_target = v.bt;
      #2;
      chk({nm, ".PCWr"}, 32'(PCWr), 32'(v.pcwr));
      if (v.chk_npc) chk({nm, ".NPC"}, NPC, v.npc);
      chk({nm, ".ifid_wr"}, 32'(ifid_wr), 32'(v.wr));
      chk({nm, ".ifid_flush"}, 32'(ifid_flush), 32'(v.fl));
      chk({nm, ".idex_flush"}, 32'(idex_flush), 32'(v.ix));
      chk({nm, ".misalign"}, 32'(misalign), 32'(v.mis));
      chk({nm, ".wr_flush_excl"}, 32'(ifid_wr & ifid_flush), 32'd0);
      @(posedge clk);
      #1;
   endtask

   vec_t tbl[10];

   initial begin
      rst = 1'b1; pc = '0; imem_ready = 1'b0; load_use = 1'b0;
      jump = 1'b0; jump_target = '0; br_taken = 1'b0; br_target = '0;

      //             rst pc            rdy lu jmp jt            br bt            pcwr npc           cn wr fl ix mis
      tbl[0] = mk(1, 32'h0000_0000, 1, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0000_3000, 1, 0, 1, 1, 0);
      tbl[1] = mk(0, 32'h0000_0000, 1, 0, 0, 32'h0,         0, 32'h0,         1, 32'h0000_3000, 1, 0, 1, 1, 0);
      tbl[2] = mk(0, 32'h0000_3000, 1, 0, 0, 32'h0,         0, 32'h0,         1, 32'h0000_3004, 1, 1, 0, 0, 0);
      tbl[3] = mk(0, 32'h0000_3004, 1, 0, 0, 32'h0,         0, 32'h0,         1, 32'h0000_3008, 1, 1, 0, 0, 0);
      tbl[4] = mk(0, 32'h0000_3010, 1, 0, 1, 32'h3200,      1, 32'h3100,      1, 32'h0000_3100, 1, 0, 1, 1, 0);
      tbl[5] = mk(0, 32'h0000_3100, 1, 0, 1, 32'h3203,      0, 32'h0,         1, 32'h0000_3200, 1, 0, 1, 0, 1);
      tbl[6] = mk(0, 32'h0000_3200, 0, 1, 0, 32'h0,         0, 32'h0,         0, 32'h0,         0, 0, 0, 1, 0);
      tbl[7] = mk(0, 32'h0000_3200, 1, 0, 0, 32'h0,         0, 32'h0,         1, 32'h0000_3204, 1, 1, 0, 0, 0);
      tbl[8] = mk(0, 32'hFFFF_FFFC, 1, 0, 0, 32'h0,         0, 32'h0,         1, 32'h0000_0000, 1, 1, 0, 0, 0);
      tbl[9] = mk(0, 32'h0000_0000, 1, 0, 0, 32'h0,         1, 32'h3001,      1, 32'h0000_3000, 1, 0, 1, 1, 1);

      for (int i = 0; i < 10; i++) begin
         step(tbl[i], $sformatf("vec%0d", i));
      end
      chk("table.stall_cnt", 32'(stall_cnt), 32'd1);
      chk("table.redir_cnt", 32'(redir_cnt), 32'd3);

      // Branch captured during an instruction-memory wait, applied three cycles later
      step(mk(0, 32'h3300, 0, 0, 0, 32'h0,    0, 32'h0,    0, 32'h0,    0, 0, 1, 0, 0), "wait.enter");
      step(mk(0, 32'h3300, 0, 1, 1, 32'h3A00, 1, 32'h3406, 0, 32'h0,    0, 0, 1, 1, 1), "wait.capture");
      step(mk(0, 32'h3300, 0, 0, 0, 32'h0,    0, 32'h0,    0, 32'h0,    0, 0, 1, 0, 0), "wait.w2");
      step(mk(0, 32'h3300, 0, 0, 0, 32'h0,    0, 32'h0,    0, 32'h0,    0, 0, 1, 0, 0), "wait.w3");
      step(mk(0, 32'h3300, 1, 0, 0, 32'h0,    0, 32'h0,    1, 32'h3404, 1, 0, 1, 0, 0), "wait.apply");
      chk("wait.stall_cnt", 32'(stall_cnt), 32'd5);
      chk("wait.redir_cnt", 32'(redir_cnt), 32'd4);
      step(mk(0, 32'h3404, 1, 0, 0, 32'h0,    0, 32'h0,    1, 32'h3408, 1, 1, 0, 0, 0), "wait.back_run");

      // Same-cycle branch beats the buffered one
      step(mk(0, 32'h3408, 0, 0, 0, 32'h0,    0, 32'h0,    0, 32'h0,    0, 0, 1, 0, 0), "same.enter");
      step(mk(0, 32'h3408, 0, 0, 0, 32'h0,    1, 32'h3500, 0, 32'h0,    0, 0, 1, 1, 0), "same.capture");
      step(mk(0, 32'h3408, 1, 0, 0, 32'h0,    1, 32'h3600, 1, 32'h3600, 1, 0, 1, 1, 0), "same.apply");

      // Newest buffered branch wins
      step(mk(0, 32'h3600, 0, 0, 0, 32'h0,    0, 32'h0,    0, 32'h0,    0, 0, 1, 0, 0), "newest.enter");
      step(mk(0, 32'h3600, 0, 0, 0, 32'h0,    1, 32'h3700, 0, 32'h0,    0, 0, 1, 1, 0), "newest.cap1");
      step(mk(0, 32'h3600, 0, 0, 0, 32'h0,    1, 32'h3800, 0, 32'h0,    0, 0, 1, 1, 0), "newest.cap2");
      step(mk(0, 32'h3600, 1, 0, 0, 32'h0,    0, 32'h0,    1, 32'h3800, 1, 0, 1, 0, 0), "newest.apply");
      chk("newest.stall_cnt", 32'(stall_cnt), 32'd10);
      chk("newest.redir_cnt", 32'(redir_cnt), 32'd6);

      // Reset during a wait discards the buffered branch and clears counters
      step(mk(0, 32'h3800, 0, 0, 0, 32'h0,    0, 32'h0,    0, 32'h0,    0, 0, 1, 0, 0), "rstw.enter");
      step(mk(0, 32'h3800, 0, 0, 0, 32'h0,    1, 32'h3900, 0, 32'h0,    0, 0, 1, 1, 0), "rstw.capture");
      step(mk(1, 32'h3800, 0, 0, 0, 32'h0,    1, 32'h3A01, 0, 32'h3000, 1, 0, 1, 1, 0), "rstw.reset");
      chk("rstw.stall_cnt", 32'(stall_cnt), 32'd0);
      chk("rstw.redir_cnt", 32'(redir_cnt), 32'd0);
      step(mk(0, 32'h0,    1, 0, 0, 32'h0,    0, 32'h0,    1, 32'h3000, 1, 0, 1, 1, 0), "rstw.boot");
      step(mk(0, 32'h3000, 0, 0, 0, 32'h0,    0, 32'h0,    0, 32'h0,    0, 0, 1, 0, 0), "rstw.enter2");
      step(mk(0, 32'h3000, 1, 0, 0, 32'h0,    0, 32'h0,    1, 32'h3004, 1, 1, 0, 0, 0), "rstw.no_redir");
      chk("rstw.redir_after", 32'(redir_cnt), 32'd0);

      // Saturation: hold a load-use stall for more than 2^16 cycles
      rst = 1'b0; pc = 32'h3004; imem_ready = 1'b1; load_use = 1'b1;
      jump = 1'b0; br_taken = 1'b0;
      repeat (65536 + 5) @(posedge clk);
      #1;
      chk("sat.stall_cnt", 32'(stall_cnt), 32'h0000_FFFF);
      chk("sat.redir_cnt", 32'(redir_cnt), 32'd0);
      chk("sat.PCWr", 32'(PCWr), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_3000, meaning boot fetch address driven after reset.
REQ-002 Parameter CNT_W, default 16, meaning width of the saturating performance counters.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 pc  input  32  current PC register value.
REQ-006 imem_ready  input  1  instruction memory has a valid word for pc this cycle.
REQ-007 load_use  input  1  ID-stage load-use hazard detected.
REQ-008 jump, jump_target  input  1/32  ID-stage jump and its target.
REQ-009 br_taken, br_target  input  1/32  EX-stage branch resolved taken and its target.
REQ-010 PCWr  output  1  PC register write enable.
REQ-011 NPC  output  32  next PC value.
REQ-012 ifid_wr, ifid_flush, idex_flush  output  1 each  pipeline register write enable and bubble injects.
REQ-013 misalign  output  1  one-cycle pulse when a redirect target has bits [1:0] != 0.
REQ-014 stall_cnt, redir_cnt  output  CNT_W each  saturating counts of stall cycles and redirects.

Function
REQ-015 FSM states BOOT, RUN, IMEM_WAIT; the control outputs (PCWr, NPC, ifid_wr, ifid_flush, idex_flush, misalign) are combinational from state, inputs and the redirect buffer, so they have 0-cycle latency.
REQ-016 BOOT: PCWr=1, NPC=RESET_PC, ifid_flush=1, idex_flush=1; next state RUN unconditionally.
REQ-017 RUN priority 1, br_taken: NPC=br_target, PCWr=1, ifid_flush=1, idex_flush=1, ifid_wr=0; stay RUN.
REQ-018 RUN priority 2, jump: NPC=jump_target, PCWr=1, ifid_flush=1, ifid_wr=0; stay RUN.
REQ-019 RUN priority 3, load_use: PCWr=0, ifid_wr=0, idex_flush=1; stay RUN regardless of imem_ready.
REQ-020 RUN priority 4, !imem_ready: PCWr=0, ifid_wr=0, ifid_flush=1; next state IMEM_WAIT.
REQ-021 RUN default: NPC=pc+4 (modulo 2^32 wrap), PCWr=1, ifid_wr=1; stay RUN.
REQ-022 IMEM_WAIT with br_taken: capture br_target in the redirect buffer (redir_vld=1, newest wins), idex_flush=1, PCWr=0.
REQ-023 IMEM_WAIT ignores jump and load_use, because ID holds a bubble.
REQ-024 IMEM_WAIT with imem_ready and redir_vld (including a same-cycle br_taken): NPC=buffered or same-cycle target (same-cycle wins), PCWr=1, ifid_flush=1, clear redir_vld; next state RUN.
REQ-025 IMEM_WAIT with imem_ready and no redirect: NPC=pc+4, PCWr=1, ifid_wr=1; next state RUN.
REQ-026 IMEM_WAIT without imem_ready: PCWr=0, ifid_wr=0, ifid_flush=1; stay.
REQ-027 Every NPC from a redirect target has bits [1:0] forced to 00, and misalign pulses that cycle.
REQ-028 stall_cnt increments on each RUN/IMEM_WAIT cycle with PCWr=0, redir_cnt on each cycle applying a branch/jump/buffered redirect; both saturate at all-ones with no wrap.
REQ-029 ifid_wr and ifid_flush are never both 1.

Reset
REQ-030 rst=1 sampled at an edge: state=BOOT, redir_vld=0, redirect buffer=0, stall_cnt=0, redir_cnt=0.
REQ-031 While rst=1, the outputs are PCWr=0, ifid_wr=0, ifid_flush=1, idex_flush=1, misalign=0, and NPC=RESET_PC.
REQ-032 rst asserted in IMEM_WAIT discards any buffered redirect.

Structure
REQ-033 Shared package fetch_ctrl_pkg holds the state enum, RESET_PC default, and the PC_INC=4 constant.
REQ-034 One sub-module, sat_counter (CNT_W parameter, inc, clear), is instantiated twice.

Verification
REQ-035 Reset then release with imem_ready=1 -> cycle 1 PCWr=1, NPC=0x0000_3000; then NPC=pc+4 each cycle.
REQ-036 RUN, pc=0x3010, br_taken=1, jump=1, br_target=0x3100, jump_target=0x3200 -> NPC=0x3100, ifid_flush=1, idex_flush=1, redir_cnt+1.
REQ-037 load_use=1 with imem_ready=0 -> PCWr=0, ifid_wr=0, idex_flush=1, state stays RUN.
REQ-038 Enter IMEM_WAIT, br_taken with target 0x3406 during the wait, imem_ready 3 cycles later -> NPC=0x3404, misalign pulse at capture, ifid_flush=1, stall_cnt +4.
REQ-039 pc=0xFFFF_FFFC with no redirect -> NPC=0x0000_0000.
REQ-040 Force 2^CNT_W+5 stall cycles -> stall_cnt holds at 0xFFFF.
